// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the performance-counter CSR block:
//   - csr_op_e   : Zicsr operation encoding (read-only / write / set / clear)
//   - CSR_*      : 12-bit CSR addresses of the counters and their aliases
//   - csr_apply  : computes the new 32-bit CSR value for a given operation
// Optional feature macro: CSR_MCOUNTINHIBIT_EN (consumed by csr_counter_file).
// ---------------------------------------------------------------------------
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_RD  = 2'b00,   // read only (CSRRS/CSRRC with rs1=x0)
        CSR_WR  = 2'b01,   // CSRRW
        CSR_SET = 2'b10,   // CSRRS
        CSR_CLR = 2'b11    // CSRRC
    } csr_op_e;

    // Machine-mode read/write counters
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // User-level read-only aliases
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    function automatic logic [31:0] csr_apply(input csr_op_e     op,
                                              input logic [31:0] old,
                                              input logic [31:0] wdata);
        case (op)
            CSR_WR:  return wdata;
            CSR_SET: return old | wdata;
            CSR_CLR: return old & ~wdata;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// ---------------------------------------------------------------------------
// csr_counter64
// One 64-bit performance counter, writable per 32-bit half.
// A write to either half takes priority over the increment for the whole
// counter: the written half loads wdata, the other half holds.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (loads RST_VAL)
//   inc               : count up by one this cycle
//   wr_lo, wr_hi      : load wdata into bits [31:0] / [63:32]
//   wdata[31:0]       : write data for the selected half
//   cnt[63:0]         : current counter value
// ---------------------------------------------------------------------------
module csr_counter64 #(
    parameter logic [63:0] RST_VAL = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt
);

    // Low half about to roll over: high half must step in the same cycle.
    logic lo_wrap;
    assign lo_wrap = &cnt[31:0];

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) cnt[31:0]  <= wdata;
            if (wr_hi) cnt[63:32] <= wdata;
        end else if (inc) begin
            cnt[31:0] <= cnt[31:0] + 32'd1;
            if (lo_wrap) cnt[63:32] <= cnt[63:32] + 32'd1;
        end
    end

endmodule

// File: rtl/csr_counter_file.sv
// ---------------------------------------------------------------------------
// csr_counter_file
// Owns the 64-bit mcycle/minstret counters and services Zicsr accesses to
// them (and to their read-only user aliases).
// Optional feature macro: CSR_MCOUNTINHIBIT_EN
//   defined   -> mcountinhibit at 0x320 (bit0 CY, bit2 IR) gates counting
//   undefined -> 0x320 is unmapped, counters always count
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   retire       : one instruction retired this cycle (from WB)
//   csr_en       : CSR instruction valid in this stage
//   csr_op       : csr_op_e encoding (00 read, 01 write, 10 set, 11 clear)
//   csr_addr     : CSR address
//   csr_wdata    : rs1 value or zero-extended uimm
//   csr_rdata    : pre-update value of the addressed CSR (0 if idle/illegal)
//   csr_illegal  : unmapped address, or modifying op on a read-only alias
//   cycle_o      : current mcycle
//   instret_o    : current minstret
// ---------------------------------------------------------------------------
module csr_counter_file
    import csr_pkg::*;
#(
    parameter int          CNT_W       = 64,
    parameter logic [63:0] CYCLE_RST   = 64'd0,
    parameter logic [63:0] INSTRET_RST = 64'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retire,
    input  logic             csr_en,
    input  logic [1:0]       csr_op,
    input  logic [11:0]      csr_addr,
    input  logic [31:0]      csr_wdata,
    output logic [31:0]      csr_rdata,
    output logic             csr_illegal,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] instret_o
);

    csr_op_e     op;
    logic        mapped;
    logic        read_only;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        do_write;
    logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
    logic        cyc_inc, ins_inc;
    logic [63:0] cycle_cnt, instret_cnt;

`ifdef CSR_MCOUNTINHIBIT_EN
    logic inh_cy;
    logic inh_ir;
`endif

    assign op = csr_op_e'(csr_op);

    // Address decode: select the addressed half and classify the address.
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held (which would infer a latch).
    always_comb begin
        mapped    = 1'b1;
        read_only = 1'b0;
        old_val   = '0;
        case (csr_addr)
            CSR_MCYCLE:    old_val = cycle_cnt[31:0];
            CSR_MCYCLEH:   old_val = cycle_cnt[63:32];
            CSR_MINSTRET:  old_val = instret_cnt[31:0];
            CSR_MINSTRETH: old_val = instret_cnt[63:32];
            CSR_CYCLE:     begin old_val = cycle_cnt[31:0];    read_only = 1'b1; end
            CSR_CYCLEH:    begin old_val = cycle_cnt[63:32];   read_only = 1'b1; end
            CSR_INSTRET:   begin old_val = instret_cnt[31:0];  read_only = 1'b1; end
            CSR_INSTRETH:  begin old_val = instret_cnt[63:32]; read_only = 1'b1; end
`ifdef CSR_MCOUNTINHIBIT_EN
            CSR_MCOUNTINHIBIT: old_val = {29'd0, inh_ir, 1'b0, inh_cy};
`else
            CSR_MCOUNTINHIBIT: mapped = 1'b0;
`endif
            default:       mapped = 1'b0;
        endcase
    end

    // A read-only op (rs1=x0) is legal on an alias; any modifying op is not.
    assign csr_illegal = csr_en & (~mapped | ((op != CSR_RD) & read_only));
    assign csr_rdata   = (csr_en & ~csr_illegal) ? old_val : 32'd0;
    assign do_write    = csr_en & (op != CSR_RD) & ~csr_illegal;
    assign new_val     = csr_apply(op, old_val, csr_wdata);

    assign cyc_wr_lo = do_write & (csr_addr == CSR_MCYCLE);
    assign cyc_wr_hi = do_write & (csr_addr == CSR_MCYCLEH);
    assign ins_wr_lo = do_write & (csr_addr == CSR_MINSTRET);
    assign ins_wr_hi = do_write & (csr_addr == CSR_MINSTRETH);

`ifdef CSR_MCOUNTINHIBIT_EN
    // Only CY (bit0) and IR (bit2) are implemented; other bits ignore writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inh_cy <= 1'b0;
            inh_ir <= 1'b0;
        end else if (do_write && (csr_addr == CSR_MCOUNTINHIBIT)) begin
            inh_cy <= new_val[0];
            inh_ir <= new_val[2];
        end
    end

    assign cyc_inc = ~inh_cy;
    assign ins_inc = retire & ~inh_ir;
`else
    assign cyc_inc = 1'b1;
    assign ins_inc = retire;
`endif

    csr_counter64 #(.RST_VAL(CYCLE_RST)) u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cyc_inc),
        .wr_lo (cyc_wr_lo),
        .wr_hi (cyc_wr_hi),
        .wdata (new_val),
        .cnt   (cycle_cnt)
    );

    // A CSR write to minstret by a retiring instruction overrides that
    // instruction's own increment (write wins inside the counter).
    csr_counter64 #(.RST_VAL(INSTRET_RST)) u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ins_inc),
        .wr_lo (ins_wr_lo),
        .wr_hi (ins_wr_hi),
        .wdata (new_val),
        .cnt   (instret_cnt)
    );

    assign cycle_o   = cycle_cnt;
    assign instret_o = instret_cnt;

endmodule

// File: tb/tb_csr_counter_file.sv
// ---------------------------------------------------------------------------
// tb_csr_counter_file
// Self-checking bench for csr_counter_file. A behavioural model holds the two
// counters as plain 64-bit integers and is compared with the DUT every cycle
// on the falling edge; directed sequences add hand-computed expectations.
// Honours CSR_MCOUNTINHIBIT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_csr_counter_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        retire, csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [63:0] cycle_o, instret_o;

    int n_checks = 0;
    int n_fail   = 0;

    csr_counter_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .retire      (retire),
        .csr_en      (csr_en),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .cycle_o     (cycle_o),
        .instret_o   (instret_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_cyc = '0;
    logic [63:0] m_ins = '0;
    logic [31:0] m_inh = '0;

    function automatic void lookup(input logic [11:0] a, output bit hit,
                                   output bit ro, output logic [31:0] val);
        hit = 1'b1; ro = 1'b0; val = '0;
        case (a)
            12'hB00: val = m_cyc[31:0];
            12'hB80: val = m_cyc[63:32];
            12'hB02: val = m_ins[31:0];
            12'hB82: val = m_ins[63:32];
            12'hC00: begin val = m_cyc[31:0];  ro = 1'b1; end
            12'hC80: begin val = m_cyc[63:32]; ro = 1'b1; end
            12'hC02: begin val = m_ins[31:0];  ro = 1'b1; end
            12'hC82: begin val = m_ins[63:32]; ro = 1'b1; end
`ifdef CSR_MCOUNTINHIBIT_EN
            12'h320: val = m_inh;
`endif
            default: hit = 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= '0;
            m_ins <= '0;
            m_inh <= '0;
        end else begin
            bit          hit, ro;
            logic [31:0] val, nv;
            logic [63:0] nc, ni;
            lookup(csr_addr, hit, ro, val);
            nc = m_cyc + ((m_inh[0]) ? 64'd0 : 64'd1);
            ni = m_ins + ((retire && !m_inh[2]) ? 64'd1 : 64'd0);
            if (csr_en && csr_op != 2'b00 && hit && !ro) begin
                case (csr_op)
                    2'b01:   nv = csr_wdata;
                    2'b10:   nv = val | csr_wdata;
                    default: nv = val & ~csr_wdata;
                endcase
                case (csr_addr)
                    12'hB00: nc = {m_cyc[63:32], nv};
                    12'hB80: nc = {nv, m_cyc[31:0]};
                    12'hB02: ni = {m_ins[63:32], nv};
                    12'hB82: ni = {nv, m_ins[31:0]};
                    default: m_inh <= nv & 32'h5;
                endcase
            end
            m_cyc <= nc;
            m_ins <= ni;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        bit          hit, ro;
        logic [31:0] val, exp_rd;
        logic        exp_ill;
        lookup(csr_addr, hit, ro, val);
        exp_ill = csr_en && (!hit || (csr_op != 2'b00 && ro));
        exp_rd  = (csr_en && !exp_ill) ? val : 32'd0;
        check("cmp_cycle_o",     cycle_o,     m_cyc);
        check("cmp_instret_o",   instret_o,   m_ins);
        check("cmp_csr_rdata",   {32'd0, csr_rdata},   {32'd0, exp_rd});
        check("cmp_csr_illegal", {63'd0, csr_illegal}, {63'd0, exp_ill});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] d, input bit ret);
        csr_en = en; csr_op = op; csr_addr = a; csr_wdata = d; retire = ret;
    endtask

    logic [11:0] pool [10] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                               12'hC80, 12'hC02, 12'hC82, 12'h320, 12'h7FF};
    int unsigned exp_ins [7] = '{1, 2, 3, 100, 101, 102, 103};
    logic [63:0] frozen_cyc;

    initial begin
        drive(0, 2'b00, 12'h000, 32'h0, 0);
        #1 rst_n = 1'b0;

        // Reset state
        mid();
        check("rst_cycle",   cycle_o,   64'd0);
        check("rst_instret", instret_o, 64'd0);
        check("rst_rdata",   {32'd0, csr_rdata}, 64'd0);
        check("rst_illegal", {63'd0, csr_illegal}, 64'd0);

        // Release, idle 10 cycles, read cycle alias
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        drive(1, 2'b00, 12'hC00, 32'h0, 0);
        mid();
        check("idle10_rdata",   {32'd0, csr_rdata}, 64'd10);
        check("idle10_cycle",   cycle_o,   64'd10);
        check("idle10_instret", instret_o, 64'd0);

        // Write mcycle low near wrap, watch carry into high half
        tick();
        drive(1, 2'b01, 12'hB00, 32'hFFFF_FFFE, 0);
        mid();
        check("wr_mcycle_old", {32'd0, csr_rdata}, 64'd11);
        tick();
        drive(0, 2'b00, 12'h000, 32'h0, 0);
        check("mcycle_fffffffe", cycle_o, 64'h0000_0000_FFFF_FFFE);
        tick();
        check("mcycle_ffffffff", cycle_o, 64'h0000_0000_FFFF_FFFF);
        tick();
        check("mcycle_carry", cycle_o, 64'h0000_0001_0000_0000);

        // Write / set / clear on minstreth
        drive(1, 2'b01, 12'hB82, 32'h0000_F0F0, 0);
        mid();
        check("minstreth_old0", {32'd0, csr_rdata}, 64'd0);
        tick();
        drive(1, 2'b10, 12'hB82, 32'h0000_000F, 0);
        mid();
        check("minstreth_wr", {32'd0, csr_rdata}, 64'h0000_F0F0);
        tick();
        drive(1, 2'b11, 12'hB82, 32'h0000_00F0, 0);
        mid();
        check("minstreth_set", {32'd0, csr_rdata}, 64'h0000_F0FF);
        tick();
        drive(1, 2'b00, 12'hB82, 32'h0, 0);
        mid();
        check("minstreth_clr", {32'd0, csr_rdata}, 64'h0000_F00F);
        tick();

        // Retire stream with a minstret write on the 4th retiring cycle
        for (int k = 0; k < 7; k++) begin
            drive(k == 3, (k == 3) ? 2'b01 : 2'b00, 12'hB02, 32'd100, 1);
            tick();
            check($sformatf("retire_seq%0d", k), {32'd0, instret_o[31:0]}, {32'd0, exp_ins[k]});
        end
        drive(0, 2'b00, 12'h000, 32'h0, 0);

        // Illegal accesses
        drive(1, 2'b01, 12'hC02, 32'h5, 0);
        mid();
        check("ro_write_illegal", {63'd0, csr_illegal}, 64'd1);
        check("ro_write_rdata",   {32'd0, csr_rdata},   64'd0);
        tick();
        check("ro_write_nochange", instret_o, 64'h0000_F00F_0000_0067);
        drive(1, 2'b00, 12'h7FF, 32'h0, 0);
        mid();
        check("unmapped_illegal", {63'd0, csr_illegal}, 64'd1);
        tick();
        drive(1, 2'b00, 12'hC02, 32'h0, 0);
        mid();
        check("ro_read_legal", {63'd0, csr_illegal}, 64'd0);
        check("ro_read_rdata", {32'd0, csr_rdata},   64'd103);
        tick();

`ifdef CSR_MCOUNTINHIBIT_EN
        // Inhibit both counters (only bits 0 and 2 stick), retire kept high
        drive(1, 2'b01, 12'h320, 32'hFFFF_FFFF, 1);
        tick();
        drive(0, 2'b00, 12'h000, 32'h0, 1);
        frozen_cyc = m_cyc;
        check("inh_instret_at_set", instret_o, 64'h0000_F00F_0000_0068);
        repeat (3) tick();
        check("inh_cycle_frozen",   cycle_o,   frozen_cyc);
        check("inh_instret_frozen", instret_o, 64'h0000_F00F_0000_0068);
        drive(1, 2'b00, 12'h320, 32'h0, 1);
        mid();
        check("inh_readback", {32'd0, csr_rdata}, 64'h5);
        tick();
        drive(1, 2'b01, 12'h320, 32'h0, 1);
        tick();
        drive(0, 2'b00, 12'h000, 32'h0, 1);
        check("inh_clear_edge_cycle", cycle_o, frozen_cyc);
        tick();
        check("inh_resume_cycle",   cycle_o,   frozen_cyc + 64'd1);
        check("inh_resume_instret", instret_o, 64'h0000_F00F_0000_0069);
        drive(0, 2'b00, 12'h000, 32'h0, 0);
`else
        drive(1, 2'b00, 12'h320, 32'h0, 0);
        mid();
        check("mcountinhibit_unmapped", {63'd0, csr_illegal}, 64'd1);
        tick();
        frozen_cyc = '0;
`endif

        // Randomized traffic, with occasional reset pulses during accesses
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] d;
            case ($urandom_range(0, 3))
                0:       d = 32'hFFFF_FFFF;
                1:       d = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: d = $urandom;
            endcase
            drive($urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 9)],
                  d,
                  $urandom_range(0, 1) == 1);
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1;
        drive(0, 2'b00, 12'h000, 32'h0, 0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_counter_file.md
Name: csr_counter_file

Overview:
- Owns the 64-bit cycle and instret performance counters and services Zicsr read/write accesses to them.
- Produces the Cycle/Instructions values consumed by the CSR read path, and now also accepts CSRRW/CSRRS/CSRRC writes.
- Sits in the EX/WB stage beside the CSR read logic. The retire strobe comes from WB.

Parameters:
- CNT_W, 64, counter width; fixed 64; halves are CNT_W/2.
- CYCLE_RST, 64'd0, reset value of mcycle.
- INSTRET_RST, 64'd0, reset value of minstret.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- retire  input  1  one instruction retired this cycle.
- csr_en  input  1  CSR instruction valid in this stage.
- csr_op  input  2  csr_op_e: 01 write, 10 set, 11 clear, 00 read-only.
- csr_addr  input  12  CSR address (instruction[31:20]).
- csr_wdata  input  32  rs1 value or zero-extended uimm.
- csr_rdata  output  32  old value of the addressed CSR.
- csr_illegal  output  1  unmapped address, or write to a read-only alias.
- cycle_o  output  64  current mcycle.
- instret_o  output  64  current minstret.

Behaviour:
- Address map:
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82: read/write.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only aliases.
- Reset: async assert clears mcycle to CYCLE_RST and minstret to INSTRET_RST immediately.
  - Outputs are combinational from state, so csr_rdata=0, csr_illegal=0 (when csr_en=0), cycle_o=0, instret_o=0 during reset.
  - Reset mid-access discards the pending write.
- Read: combinational, zero latency. csr_rdata is the pre-update register half selected by csr_addr; it is 0 when csr_en=0 or the address is illegal.
- Write effect: new = wdata (write), old|wdata (set), old&~wdata (clear). Committed on the next rising edge, visible the following cycle.
  - Write happens only if csr_en=1, csr_op!=00, address is writable, and csr_illegal=0.
  - CSRRS/CSRRC with csr_op=00 (rs1=x0) never writes and never flags illegal on read-only aliases.
- csr_illegal = csr_en & (unmapped | (csr_op!=00 & read-only alias)). No state changes when it is asserted.
- mcycle increments by 1 every cycle out of reset.
- minstret increments by 1 on cycles with retire=1.
- Carry: when the low half goes from 0xFFFFFFFF to 0, the high half increments in the same cycle. The full counter wraps from 2^64-1 to 0.
- Simultaneous write and increment on the same counter: the write wins for the whole counter, and no increment occurs that cycle.
  - Written half takes the new value; the other half holds.
  - Example: writing mcycle=5 yields mcycle=5 next cycle and 6 the cycle after.
- A write to minstret by the CSR instruction that itself retires suppresses that retire's increment, per the rule above.

Optional Feature:
- Macro: CSR_MCOUNTINHIBIT_EN.
- With it defined: adds the mcountinhibit CSR at 0x320, read/write, reset 0.
  - Bit0 (CY) set stops mcycle increments; bit2 (IR) set stops minstret increments.
  - All other bits read 0 and ignore writes. CSR writes to counters still work while inhibited.
- Without it: 0x320 is unmapped (csr_illegal=1 on access) and counters always count.

Decomposition:
- Package csr_pkg:
  - csr_op_e enum (CSR_RD, CSR_WR, CSR_SET, CSR_CLR).
  - 12-bit localparams for all eight counter addresses plus CSR_MCOUNTINHIBIT.
  - Function csr_apply(op, old, wdata) returning the 32-bit new value.
- Sub-module csr_counter64, instantiated twice (mcycle, minstret).
  - Ports: clk, rst_n, inc, wr_lo, wr_hi, wdata[31:0], cnt[63:0].
  - Owns the carry chain and the write-over-increment priority.

Test Plan:
- Reset release, idle for 10 cycles, then read 0xC00 -> csr_rdata=10, cycle_o=10, instret_o=0.
- Write mcycle (csr_op=01, addr 0xB00, wdata 0xFFFFFFFE) -> csr_rdata=old value, then mcycle low counts 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000. cycleh increments by 1 at the wrap.
- Set/clear on minstreth: write 0xB82 := 0x0000F0F0, set 0x0000000F, clear 0x000000F0 -> reads 0x0000F0F0, 0x0000F0FF, 0x0000F00F.
- retire=1 for 7 cycles, with a minstret write 100 on cycle 4 while retire=1 -> instret_o sequence 1,2,3,100,101,102,103.
- Write (csr_op=01) to 0xC02 and an access to 0x7FF -> csr_illegal=1, counters unchanged. CSRRS with csr_op=00 on 0xC02 -> csr_illegal=0.
- With CSR_MCOUNTINHIBIT_EN: write 0x320 := 0x5 -> cycle_o and instret_o freeze despite retire=1; write 0x0 -> both resume. Without the macro: access 0x320 -> csr_illegal=1.
